keyed_xor_lock_seq: RTL

- Parametrised, registered successor to the XOR/mux key-gate wrapper used on the locked ISCAS combinational cores.
- Loads a key serially into a shadow register and commits it atomically to an active key register.
- Masks the core's primary inputs and outputs with the active key through one register stage each.
- Exports the mux-select key bits to the core's internal mux-lock insertion point.

---
 rtl/keyed_xor_lock_seq.sv | 95 +++++++++
 1 files changed

// File: rtl/keyed_xor_lock_seq.sv
// rtl/keyed_xor_lock_seq.sv - serial-loaded XOR/mux key gate with atomic key commit
// Masks core inputs/outputs with the active key through one register stage each.
module keyed_xor_lock_seq #(
  parameter int IN_W     = 36,
  parameter int OUT_W    = 7,
  parameter int MUX_KEYS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_load_start,
  input  logic                key_in_valid,
  input  logic                key_in_bit,
  output logic                key_loading,
  output logic                key_active,
  input  logic                din_valid,
  input  logic [IN_W-1:0]     din,
  output logic                core_in_valid,
  output logic [IN_W-1:0]     core_in,
  input  logic                core_out_valid,
  input  logic [OUT_W-1:0]    core_out,
  output logic                dout_valid,
  output logic [OUT_W-1:0]    dout,
  output logic [MUX_KEYS-1:0] mux_key
);

  localparam int KEY_W = IN_W + OUT_W + MUX_KEYS;
  localparam int CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {LOCKED, LOAD, ACTIVE} state_t;

  state_t             state;
  logic [KEY_W-1:0]   shadow;
  logic [KEY_W-1:0]   active_key;
  logic [KEY_W-1:0]   shadow_next;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;

  // Shadow with the incoming bit merged in, so the final bit can commit on its own edge.
  always_comb begin
    shadow_next = shadow;
    for (int i = 0; i < KEY_W; i++) begin
      if (cnt == CNT_W'(i)) shadow_next[i] = key_in_bit;
    end
  end

  assign last_bit    = (cnt == CNT_W'(KEY_W - 1));
  assign key_loading = (state == LOAD);
  assign mux_key     = active_key[KEY_W-1:IN_W+OUT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOCKED;
      shadow        <= '0;
      active_key    <= '0;
      cnt           <= '0;
      key_active    <= 1'b0;
      core_in_valid <= 1'b0;
      core_in       <= '0;
      dout_valid    <= 1'b0;
      dout          <= '0;
    end else begin
      core_in_valid <= din_valid;
      if (din_valid) core_in <= din ^ active_key[IN_W-1:0];
      dout_valid <= core_out_valid;
      if (core_out_valid) dout <= core_out ^ active_key[IN_W+OUT_W-1:IN_W];

      case (state)
        LOCKED, ACTIVE: begin
          if (key_load_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          // A restart takes priority over any bit presented in the same cycle.
          if (key_load_start) begin
            cnt <= '0;
          end else if (key_in_valid) begin
            shadow <= shadow_next;
            if (last_bit) begin
              active_key <= shadow_next;
              key_active <= 1'b1;
              state      <= ACTIVE;
              cnt        <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= LOCKED;
      endcase
    end
  end

endmodule
